// File: rtl/clock_pkg.sv
// Shared definitions for the clock/time controller slice.
//   mode_t  : controller state, also driven directly onto the mode port
//   *_MAX   : last legal value of each time-of-day field
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned SEC_MAX = 59;

endpackage

// File: rtl/clock_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ input cycles.
//   clk_in : system clock
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear of the prescaler (takes priority over wrap)
//   tick   : high for the one cycle the prescaler holds CLK_HZ-1
//   half   : high while the prescaler is in the first half of its period
module clock_tick_gen #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic half
);

  localparam int unsigned CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] HALF_V = CNT_W'(CLK_HZ / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);
  assign half = (cnt_q < HALF_V);

endmodule

// File: rtl/clock_time_controller.sv
// 24-hour time-of-day clock with a two-button set interface.
//   clk_in            : system clock, CLK_HZ cycles per second
//   rst_n             : asynchronous active-low reset
//   btn_mode, btn_inc : debounced button levels, asynchronous to clk_in
//   hours/minutes/seconds : binary time of day
//   mode              : RUN / SET_HR / SET_MIN
//   blink             : display enable; toggles at 1 Hz while editing
//   sec_tick          : one-cycle pulse in the cycle seconds advance in RUN
module clock_time_controller
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_tick
);

  // bit 0 = mode button, bit 1 = inc button
  logic [1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [1:0] edges;
  logic       mode_edge, inc_edge;

  mode_t      state_q, state_d;
  logic [4:0] hr_q, hr_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       sec_tick_q, sec_tick_d;

  logic tick, half, clr;

  always_comb begin
    s1_d   = {btn_inc, btn_mode};
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // A mode edge discards a coincident inc edge.
  assign edges     = s2_q & ~prev_q;
  assign mode_edge = edges[0];
  assign inc_edge  = edges[1] & ~edges[0];

  // Restart the second on leaving SET_MIN so the first tick is a full period away.
  assign clr = mode_edge && (state_q == SET_MIN);

  clock_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (clr),
    .tick   (tick),
    .half   (half)
  );

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (mode_edge) begin
      unique case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        default: state_d = RUN;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    mode  = state_q;
    blink = (state_q == RUN) ? 1'b1 : half;
  end

  // Time-of-day datapath
  always_comb begin
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (tick) begin
          sec_tick_d = 1'b1;
          if (sec_q == 6'(SEC_MAX)) begin
            sec_d = '0;
            if (min_q == 6'(MIN_MAX)) begin
              min_d = '0;
              hr_d  = (hr_q == 5'(HR_MAX)) ? '0 : hr_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
      SET_HR: begin
        if (inc_edge) begin
          hr_d = (hr_q == 5'(HR_MAX)) ? '0 : hr_q + 5'd1;
        end
      end
      SET_MIN: begin
        if (inc_edge) begin
          min_d = (min_q == 6'(MIN_MAX)) ? '0 : min_q + 6'd1;
        end
        if (mode_edge) begin
          sec_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign hours    = hr_q;
  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign sec_tick = sec_tick_q;

endmodule
